// File: rtl/prog_mem_arbiter.sv
// Arbitrates an NV program memory between a one-word programmer buffer and the CPU; optional PROG_CHECKSUM_EN adds a committed-word checksum.
// Latency: write T_WP+2 cycles from request to cpu_ready, read T_ACC cycles after leaving IDLE; a second programmer word waits in the buffer, a third is dropped.
module prog_mem_arbiter #(
  parameter int T_WP  = 4,
  parameter int T_ACC = 3
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        PROGRAM,
  input  logic        pwe_pulse_q,
  input  logic [15:0] paddr,
  input  logic [31:0] pdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_ce_n,
  output logic        mem_we_n,
  output logic        mem_oe_n,
  output logic        cpu_reset,
  output logic [16:0] prog_words,
  output logic        prog_overrun
`ifdef PROG_CHECKSUM_EN
  ,
  output logic [31:0] prog_checksum
`endif
);

  localparam int CMAX = (T_WP > T_ACC) ? T_WP : T_ACC;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          pending;
  logic [15:0]   buf_addr;
  logic [31:0]   buf_data;
  logic          src_prog;
  logic          program_q;
  logic          prog_rise;
  logic          rst_hold;
  logic          take_prog;
  logic          commit_prog;

  assign cnt_zero    = (cnt == '0);
  assign take_prog   = (state == IDLE) && pending;
  assign commit_prog = (state == W_HOLD) && src_prog;
  assign prog_rise   = PROGRAM && !program_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pending)                   state_nxt = W_SETUP;
        else if (cpu_req && !PROGRAM)  state_nxt = cpu_we ? W_SETUP : R_ACC;
      end
      W_SETUP: state_nxt = W_PULSE;
      W_PULSE: if (cnt_zero) state_nxt = W_HOLD;
      W_HOLD:  state_nxt = IDLE;
      R_ACC:   if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ce_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_oe_n  = 1'b1;
    case (state)
      W_SETUP: mem_ce_n = 1'b0;
      W_PULSE: begin mem_ce_n = 1'b0; mem_we_n = 1'b0; end
      W_HOLD:  mem_ce_n = 1'b0;
      R_ACC:   begin mem_ce_n = 1'b0; mem_oe_n = 1'b0; end
      default: ;
    endcase
    cpu_reset = rst_hold | PROGRAM | pending | (src_prog && (state != IDLE));
  end

  // The buffer is freed as soon as the FSM takes its word, so one more word can queue behind a write in flight.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pending      <= 1'b0;
      buf_addr     <= '0;
      buf_data     <= '0;
      prog_overrun <= 1'b0;
      prog_words   <= '0;
      program_q    <= 1'b0;
      rst_hold     <= 1'b1;
    end else begin
      rst_hold  <= 1'b0;
      program_q <= PROGRAM;
      if (pwe_pulse_q && (!pending || take_prog)) begin
        buf_addr <= paddr;
        buf_data <= pdata;
        pending  <= 1'b1;
      end else if (take_prog) begin
        pending  <= 1'b0;
      end
      if (prog_rise)
        prog_overrun <= 1'b0;
      if (pwe_pulse_q && pending && !take_prog)
        prog_overrun <= 1'b1;
      if (prog_rise)
        prog_words <= '0;
      else if (commit_prog && (prog_words != '1))
        prog_words <= prog_words + 17'd1;
    end
  end

`ifdef PROG_CHECKSUM_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset)           prog_checksum <= '0;
    else if (prog_rise)   prog_checksum <= '0;
    else if (commit_prog) prog_checksum <= prog_checksum + mem_wdata;
  end
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      src_prog  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (state == IDLE) begin
        if (pending) begin
          src_prog  <= 1'b1;
          mem_addr  <= buf_addr;
          mem_wdata <= buf_data;
        end else if (cpu_req && !PROGRAM) begin
          src_prog <= 1'b0;
          mem_addr <= cpu_addr;
          if (cpu_we) mem_wdata <= cpu_wdata;
        end
      end
      if (state == W_SETUP)
        cnt <= CW'(T_WP - 1);
      else if ((state == IDLE) && (state_nxt == R_ACC))
        cnt <= CW'(T_ACC - 1);
      else if (!cnt_zero)
        cnt <= cnt - 1'b1;
      cpu_ready <= ((state == W_PULSE) && cnt_zero && !src_prog) ||
                   ((state == R_ACC) && cnt_zero);
      if ((state == R_ACC) && cnt_zero)
        cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: vector table, directed programmer/reset sequences, and random traffic against a memory-contents model.
module tb_prog_mem_arbiter;
  localparam int T_WP  = 4;
  localparam int T_ACC = 3;

  logic        clk = 1'b0;
  logic        areset;
  logic        PROGRAM;
  logic        pwe_pulse_q;
  logic [15:0] paddr;
  logic [31:0] pdata;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ce_n, mem_we_n, mem_oe_n;
  logic        cpu_reset;
  logic [16:0] prog_words;
  logic        prog_overrun;
`ifdef PROG_CHECKSUM_EN
  logic [31:0] prog_checksum;
`endif

  prog_mem_arbiter #(.T_WP(T_WP), .T_ACC(T_ACC)) dut (
    .clk(clk), .areset(areset), .PROGRAM(PROGRAM), .pwe_pulse_q(pwe_pulse_q),
    .paddr(paddr), .pdata(pdata), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n),
    .mem_oe_n(mem_oe_n), .cpu_reset(cpu_reset), .prog_words(prog_words),
    .prog_overrun(prog_overrun)
`ifdef PROG_CHECKSUM_EN
    , .prog_checksum(prog_checksum)
`endif
  );

  always #5 clk = ~clk;

  // Simple memory device on the bus; optionally overridden with a fixed read value.
  logic [31:0] mem_dev [256];
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_rdata = '0;
  assign mem_rdata = fixed_en ? fixed_rdata : mem_dev[mem_addr[7:0]];

  int          we_cnt = 0;
  int          oe_cnt = 0;
  logic        we_prev = 1'b1;
  logic [47:0] wlog [$];

  always @(negedge clk) begin
    if (!mem_we_n) begin
      we_cnt++;
      if (we_prev) begin
        wlog.push_back({mem_addr, mem_wdata});
        mem_dev[mem_addr[7:0]] = mem_wdata;
      end
    end
    if (!mem_oe_n) oe_cnt++;
    we_prev = mem_we_n;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic prog_pulse(input logic [15:0] a, input logic [31:0] d);
    pwe_pulse_q = 1'b1; paddr = a; pdata = d;
    tick();
    pwe_pulse_q = 1'b0;
  endtask

  task automatic program_rise();
    PROGRAM = 1'b0; tick();
    PROGRAM = 1'b1; tick();
  endtask

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    while (q < 3 && n < 300) begin
      tick(); n++;
      if (mem_ce_n) q++; else q = 0;
    end
    check(name, q, 3);
  endtask

  // One CPU access; address/data are scrambled after the first edge to confirm they were sampled on leaving IDLE.
  task automatic cpu_op(input bit we, input logic [15:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic [15:0] ma);
    we_cnt = 0; oe_cnt = 0; lat = -1; rd = '0; ma = '0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 1) begin cpu_addr = ~a; cpu_wdata = ~d; end
      if (!mem_ce_n) ma = mem_addr;
      if (cpu_ready) begin lat = n; rd = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_in;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_we;
    int          exp_oe;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, base, n, ce_low, rdy_seen, saw_rst, exp_words;
    logic [31:0] rd;
    logic [15:0] ma;
    logic [31:0] model [256];
    logic [15:0] a, a2;
    logic [31:0] d, d2;
    int          r;

    vecs[0] = '{0, 16'h0010, 32'h0,        32'h12345678, 32'h12345678, T_ACC + 1, 0,    T_ACC};
    vecs[1] = '{1, 16'h0020, 32'hCAFEF00D, 32'h0,        32'h0,        T_WP + 2,  T_WP, 0};
    vecs[2] = '{0, 16'h007F, 32'h0,        32'h0,        32'h0,        T_ACC + 1, 0,    T_ACC};
    vecs[3] = '{1, 16'hFFFF, 32'h00000001, 32'h0,        32'h0,        T_WP + 2,  T_WP, 0};
    vecs[4] = '{0, 16'h0000, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, T_ACC + 1, 0,    T_ACC};
    vecs[5] = '{0, 16'h0ABC, 32'h0,        32'hA5A55A5A, 32'hA5A55A5A, T_ACC + 1, 0,    T_ACC};

    for (int i = 0; i < 256; i++) mem_dev[i] = '0;
    areset = 1'b1; PROGRAM = 1'b0; pwe_pulse_q = 1'b0; paddr = '0; pdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) tick();

    check("rst ce_n", mem_ce_n, 1);
    check("rst we_n", mem_we_n, 1);
    check("rst oe_n", mem_oe_n, 1);
    check("rst ready", cpu_ready, 0);
    check("rst rdata", cpu_rdata, 0);
    check("rst addr", mem_addr, 0);
    check("rst wdata", mem_wdata, 0);
    check("rst words", prog_words, 0);
    check("rst overrun", prog_overrun, 0);
    check("rst cpu_reset", cpu_reset, 1);
    @(negedge clk) areset = 1'b0;
    #1 check("cpu_reset before first edge", cpu_reset, 1);
    tick();
    check("cpu_reset after release", cpu_reset, 0);

    fixed_en = 1'b1;
    foreach (vecs[i]) begin
      fixed_rdata = vecs[i].rdata_in;
      cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, ma);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d we_n low cycles", i), we_cnt, vecs[i].exp_we);
      check($sformatf("vec%0d oe_n low cycles", i), oe_cnt, vecs[i].exp_oe);
      check($sformatf("vec%0d mem_addr", i), ma, vecs[i].addr);
      if (vecs[i].we) check($sformatf("vec%0d written word", i), wlog[$], {vecs[i].addr, vecs[i].wdata});
      else            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
    end
    fixed_en = 1'b0;

    // Single programmer word
    program_rise();
    base = wlog.size(); we_cnt = 0;
    prog_pulse(16'h0005, 32'hDEADBEEF);
    wait_quiet("p1 quiet");
    check("p1 we_n low cycles", we_cnt, T_WP);
    check("p1 log size", wlog.size(), base + 1);
    check("p1 word", wlog[base], {16'h0005, 32'hDEADBEEF});
    check("p1 mem_addr", mem_addr, 16'h0005);
    check("p1 words", prog_words, 1);
    check("p1 cpu_reset", cpu_reset, 1);

    // Two pulses two cycles apart: both committed
    program_rise();
    check("rise clears words", prog_words, 0);
    base = wlog.size();
    prog_pulse(16'h0100, 32'h11111111);
    tick();
    prog_pulse(16'h0101, 32'h22222222);
    wait_quiet("p2 quiet");
    check("p2 words", prog_words, 2);
    check("p2 overrun", prog_overrun, 0);
    check("p2 first", wlog[base], {16'h0100, 32'h11111111});
    check("p2 second", wlog[base + 1], {16'h0101, 32'h22222222});

    // Three back-to-back pulses: the third is dropped
    program_rise();
    base = wlog.size();
    prog_pulse(16'h0200, 32'hA0000000);
    prog_pulse(16'h0201, 32'hA0000001);
    prog_pulse(16'h0202, 32'hA0000002);
    wait_quiet("p3 quiet");
    check("p3 overrun", prog_overrun, 1);
    check("p3 words", prog_words, 2);
    check("p3 log size", wlog.size(), base + 2);
    check("p3 second", wlog[base + 1], {16'h0201, 32'hA0000001});
    program_rise();
    check("rise clears overrun", prog_overrun, 0);
    check("rise clears words again", prog_words, 0);

    // PROGRAM falls mid-write with a word still buffered
    base = wlog.size();
    prog_pulse(16'h0300, 32'hB0000000);
    prog_pulse(16'h0301, 32'hB0000001);
    PROGRAM = 1'b0;
    wait_quiet("p4 quiet");
    check("p4 words", prog_words, 2);
    check("p4 log size", wlog.size(), base + 2);
    check("p4 buffered word", wlog[base + 1], {16'h0301, 32'hB0000001});
    check("p4 cpu_reset released", cpu_reset, 0);

    // Buffered programmer word beats a concurrent CPU write
    base = wlog.size();
    prog_pulse(16'h0030, 32'hC0C0C0C0);
    cpu_we = 1'b1; cpu_addr = 16'h0031; cpu_wdata = 32'hD1D1D1D1; cpu_req = 1'b1;
    rdy_seen = 0; saw_rst = 0;
    for (int k = 0; k < 60 && rdy_seen == 0; k++) begin
      tick();
      if (cpu_reset) saw_rst = 1;
      if (cpu_ready) rdy_seen = 1;
    end
    cpu_req = 1'b0;
    wait_quiet("p5 quiet");
    check("p5 cpu ready", rdy_seen, 1);
    check("p5 cpu_reset during prog", saw_rst, 1);
    check("p5 prog first", wlog[base], {16'h0030, 32'hC0C0C0C0});
    check("p5 cpu second", wlog[base + 1], {16'h0031, 32'hD1D1D1D1});
    check("p5 words", prog_words, 3);

    // CPU requests ignored while PROGRAM is high
    program_rise();
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    ce_low = 0; rdy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!mem_ce_n) ce_low++;
      if (cpu_ready) rdy_seen++;
    end
    cpu_req = 1'b0;
    check("prog blocks cpu strobes", ce_low, 0);
    check("prog blocks cpu ready", rdy_seen, 0);

    // Reset in the middle of a write pulse, second word buffered
    prog_pulse(16'h0400, 32'h00000400);
    wait_quiet("p6 quiet");
    check("p6 words before reset", prog_words, 1);
    base = wlog.size();
    prog_pulse(16'h0401, 32'h00000401);
    prog_pulse(16'h0402, 32'h00000402);
    n = 0;
    while (mem_we_n && n < 20) begin tick(); n++; end
    check("p6 reached pulse", mem_we_n, 0);
    areset = 1'b1; PROGRAM = 1'b0;
    #1;
    check("arst we_n", mem_we_n, 1);
    check("arst ce_n", mem_ce_n, 1);
    check("arst cpu_reset", cpu_reset, 1);
    check("arst words", prog_words, 0);
    check("arst rdata", cpu_rdata, 0);
    check("arst addr", mem_addr, 0);
    check("arst wdata", mem_wdata, 0);
    @(negedge clk) areset = 1'b0;
    #1 check("arst cpu_reset held", cpu_reset, 1);
    tick();
    check("arst pending cleared", cpu_reset, 0);
    repeat (10) tick();
    check("arst no write", wlog.size(), base);

`ifdef PROG_CHECKSUM_EN
    program_rise();
    prog_pulse(16'h0500, 32'h00000001); wait_quiet("cs quiet 1");
    prog_pulse(16'h0501, 32'h00000002); wait_quiet("cs quiet 2");
    prog_pulse(16'h0502, 32'hFFFFFFFF); wait_quiet("cs quiet 3");
    check("checksum", prog_checksum, 32'h00000002);
    check("checksum words", prog_words, 3);
    PROGRAM = 1'b0; tick();
`endif

    // Random CPU/programmer traffic against a memory-contents model
    program_rise();
    PROGRAM = 1'b0;
    tick();
    exp_words = 0;
    for (int i = 0; i < 256; i++) begin model[i] = '0; mem_dev[i] = '0; end
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      a = {8'h00, 4'h8, 4'($urandom_range(0, 15))};
      d = $urandom;
      if (r < 2) begin
        prog_pulse(a, d);
        model[a[7:0]] = d; exp_words++;
        if ($urandom_range(0, 1) == 1) begin
          a2 = {8'h00, 4'h8, 4'($urandom_range(0, 15))};
          d2 = $urandom;
          prog_pulse(a2, d2);
          model[a2[7:0]] = d2; exp_words++;
        end
        wait_quiet($sformatf("rnd%0d quiet", it));
      end else if (r < 6) begin
        cpu_op(1'b1, a, d, lat, rd, ma);
        model[a[7:0]] = d;
        check($sformatf("rnd%0d wr latency", it), lat, T_WP + 2);
      end else begin
        cpu_op(1'b0, a, d, lat, rd, ma);
        check($sformatf("rnd%0d rd latency", it), lat, T_ACC + 1);
        check($sformatf("rnd%0d rd data @%0h", it, a), rd, model[a[7:0]]);
      end
    end
    check("rnd words", prog_words, exp_words);
    check("rnd overrun", prog_overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
